// File: rtl/frame_align_ctrl.sv
// frame_align_ctrl: bitslip alignment controller for an 8-bit ISERDESE2 frame-clock deserializer
module frame_align_ctrl #(
    parameter logic [7:0] FRAME_PATTERN = 8'hF0,
    parameter int         SETTLE_CYCLES = 4,
    parameter int         MATCH_COUNT   = 8,
    parameter int         MAX_SLIPS     = 16,
    parameter int         LOSS_COUNT    = 4
) (
    input  logic                               CLK,
    input  logic                               RST_N,
    input  logic                               start,
    input  logic [7:0]                         frame_data,
    output logic                               bitslip,
    output logic                               aligned,
    output logic                               align_fail,
    output logic                               lock_lost,
    output logic [$clog2(MAX_SLIPS+1)-1:0]     slip_count
);
    localparam int SCW = $clog2(MAX_SLIPS + 1);
    localparam int SW  = $clog2(SETTLE_CYCLES + 1);
    localparam int MW  = $clog2(MATCH_COUNT + 1);
    localparam int LW  = $clog2(LOSS_COUNT + 1);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SETTLE = 3'd1;
    localparam logic [2:0] CHECK  = 3'd2;
    localparam logic [2:0] SLIP   = 3'd3;
    localparam logic [2:0] LOCKED = 3'd4;
    localparam logic [2:0] FAIL   = 3'd5;

    logic [2:0]     state_q, state_d;
    logic [SW-1:0]  settle_q, settle_d;
    logic [MW-1:0]  match_q, match_d;
    logic [LW-1:0]  miss_q, miss_d;
    logic [SCW-1:0] slip_q, slip_d;
    logic           bitslip_q, bitslip_d;
    logic           aligned_q, aligned_d;
    logic           fail_q, fail_d;
    logic           lost_q, lost_d;
    logic           hit;

    assign hit        = frame_data == FRAME_PATTERN;
    assign bitslip    = bitslip_q;
    assign aligned    = aligned_q;
    assign align_fail = fail_q;
    assign lock_lost  = lost_q;
    assign slip_count = slip_q;

    // Next-state logic; aligned only asserts from the second LOCKED cycle, so lock is reported one edge after entry
    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        match_d   = match_q;
        miss_d    = miss_q;
        slip_d    = slip_q;
        bitslip_d = 1'b0;
        lost_d    = 1'b0;
        if (!start) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d  = SETTLE;
                    settle_d = SW'(SETTLE_CYCLES);
                    slip_d   = '0;
                end
                SETTLE: begin
                    settle_d = settle_q - SW'(1);
                    if (settle_q <= SW'(1)) begin
                        state_d = CHECK;
                        match_d = '0;
                    end
                end
                CHECK: begin
                    if (hit) begin
                        match_d = match_q + MW'(1);
                        if (match_q == MW'(MATCH_COUNT - 1)) begin
                            state_d = LOCKED;
                            miss_d  = '0;
                        end
                    end else if (slip_q >= SCW'(MAX_SLIPS)) begin
                        state_d = FAIL;
                    end else begin
                        state_d   = SLIP;
                        bitslip_d = 1'b1;
                        slip_d    = slip_q + SCW'(1);
                        match_d   = '0;
                    end
                end
                SLIP: begin
                    state_d  = SETTLE;
                    settle_d = SW'(SETTLE_CYCLES);
                end
                LOCKED: begin
                    if (hit) begin
                        miss_d = '0;
                    end else if (miss_q == LW'(LOSS_COUNT - 1)) begin
                        state_d  = SETTLE;
                        settle_d = SW'(SETTLE_CYCLES);
                        slip_d   = '0;
                        miss_d   = '0;
                        lost_d   = 1'b1;
                    end else begin
                        miss_d = miss_q + LW'(1);
                    end
                end
                FAIL: state_d = FAIL;
                default: state_d = IDLE;
            endcase
        end
        aligned_d = state_q == LOCKED && state_d == LOCKED;
        fail_d    = state_d == FAIL;
    end

    // State and registered outputs with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            settle_q  <= '0;
            match_q   <= '0;
            miss_q    <= '0;
            slip_q    <= '0;
            bitslip_q <= 1'b0;
            aligned_q <= 1'b0;
            fail_q    <= 1'b0;
            lost_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            match_q   <= match_d;
            miss_q    <= miss_d;
            slip_q    <= slip_d;
            bitslip_q <= bitslip_d;
            aligned_q <= aligned_d;
            fail_q    <= fail_d;
            lost_q    <= lost_d;
        end
    end
endmodule

// File: tb/tb_frame_align_ctrl.sv
// tb_frame_align_ctrl: randomized self-checking bench with a timing-rule reference model
module tb_frame_align_ctrl;
    localparam logic [7:0] FP = 8'hF0;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       start = 1'b0;
    logic [7:0] frame_data = 8'h00;
    logic       bitslip, aligned, align_fail, lock_lost;
    logic [4:0] slip_count;

    int tests = 0;
    int fails = 0;

    frame_align_ctrl dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .frame_data(frame_data),
        .bitslip(bitslip), .aligned(aligned), .align_fail(align_fail),
        .lock_lost(lock_lost), .slip_count(slip_count)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        start = 1'b0;
        tick();
        tick();
        RST_N = 1'b1;
    endtask

    // Deserializer output with the bit phase rotated by r positions
    function automatic logic [7:0] rotw(int r);
        logic [15:0] d;
        d = {FP, FP} << (r % 8);
        return d[15:8];
    endfunction

    function automatic logic [7:0] rand_miss();
        logic [7:0] w;
        w = 8'($urandom);
        return (w == FP) ? 8'h0F : w;
    endfunction

    task automatic test_reset();
        RST_N = 1'b0;
        start = 1'b1;
        frame_data = FP;
        tick();
        tests++;
        if ({bitslip, aligned, align_fail, lock_lost, slip_count} !== 9'b0) begin
            fails++;
            $display("FAIL reset got=%b exp=%b", {bitslip, aligned, align_fail, lock_lost, slip_count}, 9'b0);
        end
        start = 1'b0;
        tick();
        RST_N = 1'b1;
    endtask

    // Input starts k slips away from the pattern; every slip moves the phase by one bit
    task automatic test_align(int k);
        int nsl = 0;
        int last = 6 * k + 16;
        logic [8:0] got, exp;
        do_reset();
        frame_data = rotw(8 - k);
        start = 1'b1;
        for (int e = 1; e <= last; e++) begin
            tick();
            if (bitslip) nsl++;
            frame_data = rotw(8 - k + nsl);
            exp = {k > 0 && e % 6 == 0 && e / 6 <= k, e >= 6 * k + 14, 1'b0, 1'b0,
                   5'((e / 6 < k) ? e / 6 : k)};
            got = {bitslip, aligned, align_fail, lock_lost, slip_count};
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL align k=%0d edge=%0d got=%b exp=%b", k, e, got, exp);
            end
        end
        start = 1'b0;
        tick();
        tests++;
        if ({aligned, bitslip, slip_count} !== {1'b0, 1'b0, 5'(k)}) begin
            fails++;
            $display("FAIL align_abort k=%0d got=%b exp=%b", k, {aligned, bitslip, slip_count}, {1'b0, 1'b0, 5'(k)});
        end
    endtask

    task automatic test_no_pattern();
        logic [8:0] got, exp;
        do_reset();
        start = 1'b1;
        for (int e = 1; e <= 110; e++) begin
            frame_data = rand_miss();
            tick();
            exp = {e % 6 == 0 && e <= 96, 1'b0, e >= 102, 1'b0, 5'((e / 6 > 16) ? 16 : e / 6)};
            got = {bitslip, aligned, align_fail, lock_lost, slip_count};
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL no_pattern edge=%0d got=%b exp=%b", e, got, exp);
            end
        end
        start = 1'b0;
        tick();
        tests++;
        if ({align_fail, bitslip, slip_count} !== {1'b0, 1'b0, 5'd16}) begin
            fails++;
            $display("FAIL no_pattern_abort got=%b exp=%b", {align_fail, bitslip, slip_count}, {1'b0, 1'b0, 5'd16});
        end
    endtask

    task automatic test_loss();
        int run = 0;
        logic [8:0] got, exp;
        do_reset();
        start = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            frame_data = (e <= 6) ? 8'h00 : FP;
            tick();
        end
        tests++;
        if ({aligned, slip_count} !== {1'b1, 5'd1}) begin
            fails++;
            $display("FAIL loss_lock got=%b exp=%b", {aligned, slip_count}, {1'b1, 5'd1});
        end
        for (int i = 0; i < 44; i++) begin
            if (i >= 40) frame_data = (i == 43) ? FP : rand_miss();
            else if (run == 3 || $urandom_range(0, 1) == 0) frame_data = FP;
            else frame_data = rand_miss();
            run = (frame_data == FP) ? 0 : run + 1;
            tick();
            tests++;
            if ({aligned, lock_lost, bitslip} !== 3'b100) begin
                fails++;
                $display("FAIL loss_glitch i=%0d got=%b exp=%b", i, {aligned, lock_lost, bitslip}, 3'b100);
            end
        end
        for (int i = 1; i <= 4; i++) begin
            frame_data = 8'h0F;
            tick();
            exp = (i == 4) ? {1'b0, 1'b0, 1'b0, 1'b1, 5'd0} : {1'b0, 1'b1, 1'b0, 1'b0, 5'd1};
            got = {bitslip, aligned, align_fail, lock_lost, slip_count};
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL loss_miss i=%0d got=%b exp=%b", i, got, exp);
            end
        end
        frame_data = FP;
        for (int e = 1; e <= 14; e++) begin
            tick();
            exp = {1'b0, e >= 13, 1'b0, 1'b0, 5'd0};
            got = {bitslip, aligned, align_fail, lock_lost, slip_count};
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL loss_realign edge=%0d got=%b exp=%b", e, got, exp);
            end
        end
    endtask

    // m matches then one mismatch in the first check window
    task automatic test_partial(int m);
        logic [8:0] got, exp;
        do_reset();
        start = 1'b1;
        for (int e = 1; e <= 22 + m; e++) begin
            frame_data = (e == 6 + m) ? rand_miss() : FP;
            tick();
            exp = {e == 6 + m, e >= 20 + m, 1'b0, 1'b0, 5'(e >= 6 + m)};
            got = {bitslip, aligned, align_fail, lock_lost, slip_count};
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL partial m=%0d edge=%0d got=%b exp=%b", m, e, got, exp);
            end
        end
    endtask

    task automatic test_abort();
        logic [8:0] got;
        do_reset();
        frame_data = 8'h00;
        start = 1'b1;
        repeat (6) tick();
        tests++;
        if (bitslip !== 1'b1) begin
            fails++;
            $display("FAIL abort_slip got=%b exp=1", bitslip);
        end
        RST_N = 1'b0;
        tick();
        got = {bitslip, aligned, align_fail, lock_lost, slip_count};
        tests++;
        if (got !== 9'b0) begin
            fails++;
            $display("FAIL abort_reset got=%b exp=%b", got, 9'b0);
        end
        RST_N = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            tests++;
            if ({bitslip, slip_count} !== {e == 6, 5'(e >= 6)}) begin
                fails++;
                $display("FAIL abort_restart edge=%0d got=%b exp=%b", e, {bitslip, slip_count}, {e == 6, 5'(e >= 6)});
            end
        end
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            got = {bitslip, aligned, align_fail, lock_lost, slip_count};
            tests++;
            if (got !== {4'b0, 5'd1}) begin
                fails++;
                $display("FAIL abort_settle i=%0d got=%b exp=%b", i, got, {4'b0, 5'd1});
            end
        end
        frame_data = FP;
        start = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            tick();
            tests++;
            if ({bitslip, aligned, slip_count} !== {1'b0, e >= 14, 5'd0}) begin
                fails++;
                $display("FAIL abort_resume edge=%0d got=%b exp=%b", e, {bitslip, aligned, slip_count}, {1'b0, e >= 14, 5'd0});
            end
        end
    endtask

    initial begin
        test_reset();
        test_align(0);
        test_align(3);
        for (int i = 0; i < 3; i++) test_align($urandom_range(1, 7));
        test_no_pattern();
        test_loss();
        test_partial(5);
        for (int i = 0; i < 2; i++) test_partial($urandom_range(1, 7));
        test_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/frame_align_ctrl.md
Name: frame_align_ctrl

Overview:
- Bitslip alignment controller for the 8-bit frame-clock deserializer. That deserializer is an ISERDESE2 in DDR, 8-bit, NETWORKING mode.
- Runs entirely in the CLKDIV domain. Watches the deserialized frame word and issues single-cycle bitslip pulses until the word equals the expected frame pattern.
- Confirms lock over consecutive matches, then monitors continuously. Reports lock, loss of lock and alignment failure to the ADC capture logic.

Parameters:
- FRAME_PATTERN, 8'hF0, expected deserialized frame word when aligned.
- SETTLE_CYCLES, 4, cycles to wait after a bitslip (or start) before sampling; min 3, covers ISERDES bitslip/output latency.
- MATCH_COUNT, 8, consecutive matching words needed to declare lock; min 1.
- MAX_SLIPS, 16, bitslips attempted before failing; 16 = two full DDR rotations.
- LOSS_COUNT, 4, consecutive mismatches while locked that declare loss of lock; min 1.

Ports:
- CLK  input  1  divided clock (same as the deserializer CLKDIV); all logic on rising edge.
- RST_N  input  1  synchronous, active-low reset.
- start  input  1  level: high = run alignment/monitoring; low = abort to IDLE.
- frame_data  input  8  parallel word from the frame deserializer, one new word per CLK.
- bitslip  output  1  one-cycle pulse to the deserializer BITSLIP pin.
- aligned  output  1  high while locked.
- align_fail  output  1  high after MAX_SLIPS attempts without lock.
- lock_lost  output  1  one-cycle pulse on LOSS_COUNT consecutive mismatches while locked.
- slip_count  output  $clog2(MAX_SLIPS+1)  bitslips issued in the current attempt.

Behaviour:
- One clock (CLK); reset is synchronous and active-low (RST_N). RST_N low at a rising edge forces state=IDLE. It also forces bitslip=0, aligned=0, align_fail=0, lock_lost=0, slip_count=0 and clears all internal counters, including mid-slip or mid-settle.
- All outputs are registered. No combinational path runs from inputs to outputs.
- start low at any edge (outside reset): next state IDLE, aligned=0, align_fail=0, bitslip=0. slip_count is held for readback.
- IDLE: start high -> SETTLE. The settle counter loads SETTLE_CYCLES and slip_count clears to 0.
- SETTLE: decrement the counter each cycle and ignore frame_data. At 0 -> CHECK, with match_cnt=0.
- CHECK: compare frame_data == FRAME_PATTERN every cycle.
  - On a match, match_cnt increments. On the MATCH_COUNT-th consecutive match -> LOCKED, and aligned=1 on the next edge.
  - On a mismatch with slip_count == MAX_SLIPS -> FAIL.
  - On a mismatch with slip_count < MAX_SLIPS -> SLIP. match_cnt resets.
- SLIP: one cycle only. bitslip=1 for exactly this cycle, slip_count increments, then -> SETTLE with the counter reloaded.
  - Consecutive bitslip pulses are therefore separated by at least SETTLE_CYCLES+2 cycles.
  - The ISERDESE2 requirement of at least 2 CLKDIV cycles between slips is always met.
- LOCKED: aligned=1. miss_cnt counts consecutive mismatches, and any match clears it.
  - When miss_cnt reaches LOSS_COUNT: lock_lost pulses for 1 cycle, aligned=0, slip_count=0, then -> SETTLE (automatic realignment).
  - Fewer than LOSS_COUNT mismatches have no effect.
- FAIL: align_fail=1 and no bitslip is issued. The block stays here until start goes low (-> IDLE) or reset.
- Simultaneous events:
  - Reset overrides everything.
  - start low overrides FSM transitions and the lock_lost pulse.
  - A match on the last settle cycle is ignored.
- slip_count saturates at MAX_SLIPS and never wraps.
- Latency with an already-aligned input, measured from the first edge sampling start=1: aligned rises after SETTLE_CYCLES+MATCH_COUNT+2 edges (14 with defaults).

Test Plan:
1. Already aligned: frame_data held 8'hF0, start=1 -> no bitslip pulse; aligned=1 on edge 14; slip_count=0; align_fail=0.
2. Misaligned by 3: bench model rotates the word on each bitslip and starts 3 slips from 8'hF0.
   - Expect exactly 3 bitslip pulses, each 1 cycle wide and spaced 6 cycles apart.
   - Expect aligned=1 with slip_count=3.
3. No pattern: frame_data=8'h00 constant -> 16 bitslip pulses, then align_fail=1 with slip_count=16 and no further pulses. Dropping start -> IDLE with align_fail=0.
4. Loss of lock after lock is reached:
   - Inject 3 mismatching words followed by 8'hF0 -> aligned stays 1.
   - Then inject 4 consecutive 8'h0F -> lock_lost pulses exactly 1 cycle, aligned=0, slip_count=0, and realignment begins after 4 settle cycles.
5. Partial match: 5 matches then 1 mismatch in CHECK -> bitslip pulses on the following cycle, and match_cnt restarts from 0 (lock needs 8 fresh matches).
6. Reset/abort mid-operation:
   - RST_N=0 for one edge during SLIP -> the next cycle shows bitslip=0, all outputs 0, state IDLE.
   - start=0 during SETTLE -> IDLE, with slip_count held at its current value.
